ticket_fifo_ctrl: RTL and testbench

- Sequencing controller that turns the team's simple dual-port RAM (ticket_fifo: one write port, one read port, 1-cycle registered read, old data returned on same-address read/write) into a first-word-fall-through FIFO.
- Provides a valid/ready push port, a valid/ready pop port, occupancy, a high-water mark and a synchronous flush.
- Sits between the ticket producer and the packet scheduler's ticket consumer.

---
 rtl/ticket_fifo_pkg.sv | 20 ++
 rtl/ticket_fifo.sv | 36 +++
 rtl/ticket_fifo_ctrl.sv | 137 +++++++++++++
 tb/tb_ticket_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ticket_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ticket_fifo_pkg
// Brief    : Shared ticket word width, FIFO geometry defaults and helpers.
// Revision : 1.0
// ============================================================================
package ticket_fifo_pkg;

  // Ticket word width shared with the packet scheduler.
  localparam int c_TICKET_WIDTH = 68;

  localparam int c_DATA_WIDTH = c_TICKET_WIDTH;
  localparam int c_ADDR_WIDTH = 4;

  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ticket_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ticket_fifo
// Brief    : Simple dual-port RAM, one write port, one registered read port.
// Revision : 1.0
// ============================================================================
module ticket_fifo
  import ticket_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wraddr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddr,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int unsigned c_DEPTH = depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  // Same-address read/write returns the old word (read sees pre-write array).
  always_ff @(posedge clk) begin
    if (wren) r_mem[wraddr] <= data;
    if (rden) r_q <= r_mem[rdaddr];
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/ticket_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ticket_fifo_ctrl
// Brief    : First-word-fall-through FIFO around the ticket_fifo RAM with a
//            2-entry registered output stage, occupancy and high-water mark.
// Revision : 1.0
// ============================================================================
module ticket_fifo_ctrl
  import ticket_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] usedw,
  output logic [ADDR_WIDTH+1:0] hwm
);

  localparam int unsigned        c_DEPTH    = depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] c_FULL_CNT = c_DEPTH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_rd_pend;
  logic                  r_out_valid;
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [ADDR_WIDTH+1:0] r_usedw;
  logic [ADDR_WIDTH+1:0] r_hwm;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_out_keep;
  logic [1:0]            w_stage_load;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic [ADDR_WIDTH:0]   w_ram_cnt_nxt;
  logic [ADDR_WIDTH+1:0] w_usedw_nxt;

  assign in_ready = !rst && (r_ram_cnt != c_FULL_CNT);
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = r_out_valid && out_ready && !flush;

  // Entries held or already on their way into the output stage after this pop.
  assign w_stage_load = {1'b0, r_out_valid} + {1'b0, r_skid_valid}
                      + {1'b0, r_rd_pend} - {1'b0, w_pop};
  assign w_issue      = !flush && (r_ram_cnt != '0) && (w_stage_load < 2'd2);
  assign w_out_keep   = r_out_valid && !w_pop;

  assign w_ram_cnt_nxt = r_ram_cnt + {{ADDR_WIDTH{1'b0}}, w_push}
                       - {{ADDR_WIDTH{1'b0}}, w_issue};
  assign w_usedw_nxt   = r_usedw + {{(ADDR_WIDTH+1){1'b0}}, w_push}
                       - {{(ADDR_WIDTH+1){1'b0}}, w_pop};

  ticket_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wren   (w_push),
    .wraddr (r_wr_ptr),
    .data   (in_data),
    .rden   (w_issue),
    .rdaddr (r_rd_ptr),
    .q      (w_ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_rd_pend <= 1'b0;
      r_usedw   <= '0;
      r_hwm     <= '0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_rd_pend <= 1'b0;
      r_usedw   <= '0;
      r_hwm     <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_cnt <= w_ram_cnt_nxt;
      r_rd_pend <= w_issue;
      r_usedw   <= w_usedw_nxt;
      if (w_usedw_nxt > r_hwm) r_hwm <= w_usedw_nxt;
    end
  end

  // Output stage: skid drains into the output register before any returning word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!w_out_keep) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= r_rd_pend;
        if (r_rd_pend) r_skid_data <= w_ram_q;
      end else if (r_rd_pend) begin
        r_out_data  <= w_ram_q;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (r_rd_pend) begin
      r_skid_data  <= w_ram_q;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign usedw     = r_usedw;
  assign hwm       = r_hwm;

endmodule
`default_nettype wire

// File: tb/tb_ticket_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ticket_fifo_ctrl
// Brief    : Directed vector table plus corner-case sequences for the FIFO.
// Revision : 1.0
// ============================================================================
module tb_ticket_fifo_ctrl;

  localparam int DW = 68;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW+1:0] usedw;
  logic [AW+1:0] hwm;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ticket_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .usedw     (usedw),
    .hwm       (hwm)
  );

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] din;
    logic          rdy;
    logic          exp_ir;
    logic          exp_ov;
    logic          chk_d;
    logic [DW-1:0] exp_d;
    logic [AW+1:0] exp_used;
    logic [AW+1:0] exp_hwm;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          acc, pop, hold_prev;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] sb [$];
    int            n_acc, n_pop, pushed, popped, first_c, last_c, bad, found;

    // Single push (edge k = vector k), then two pushes held under back-pressure.
    vecs[0]  = '{1'b1, 68'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 68'h0,  6'd1, 6'd1};
    vecs[1]  = '{1'b0, 68'h0,  1'b1, 1'b1, 1'b0, 1'b0, 68'h0,  6'd1, 6'd1};
    vecs[2]  = '{1'b0, 68'h0,  1'b1, 1'b1, 1'b1, 1'b1, 68'hA5, 6'd1, 6'd1};
    vecs[3]  = '{1'b0, 68'h0,  1'b1, 1'b1, 1'b0, 1'b1, 68'hA5, 6'd0, 6'd1};
    vecs[4]  = '{1'b0, 68'h0,  1'b0, 1'b1, 1'b0, 1'b0, 68'h0,  6'd0, 6'd1};
    vecs[5]  = '{1'b1, 68'hB1, 1'b0, 1'b1, 1'b0, 1'b0, 68'h0,  6'd1, 6'd1};
    vecs[6]  = '{1'b1, 68'hB2, 1'b0, 1'b1, 1'b0, 1'b0, 68'h0,  6'd2, 6'd2};
    vecs[7]  = '{1'b0, 68'h0,  1'b0, 1'b1, 1'b1, 1'b1, 68'hB1, 6'd2, 6'd2};
    vecs[8]  = '{1'b0, 68'h0,  1'b0, 1'b1, 1'b1, 1'b1, 68'hB1, 6'd2, 6'd2};
    vecs[9]  = '{1'b0, 68'h0,  1'b1, 1'b1, 1'b1, 1'b1, 68'hB2, 6'd1, 6'd2};
    vecs[10] = '{1'b0, 68'h0,  1'b1, 1'b1, 1'b0, 1'b1, 68'hB2, 6'd0, 6'd2};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_usedw", usedw, 0);
    check("rst_hwm", hwm, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 11; i++) begin
      in_valid = vecs[i].vld; in_data = vecs[i].din; out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ir);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      check($sformatf("vec%0d_usedw", i), usedw, vecs[i].exp_used);
      check($sformatf("vec%0d_hwm", i), hwm, vecs[i].exp_hwm);
      if (vecs[i].chk_d) check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_d);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Fill to full: 16 RAM words plus 2 in the output stage.
    n_acc = 0;
    for (int c = 0; c < 25; c++) begin
      in_valid = (n_acc < 20); in_data = DW'(n_acc + 1);
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        n_acc++;
        if (n_acc == 18) check("fill_in_ready_after_18", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    check("fill_accepted", n_acc, 18);
    check("fill_usedw", usedw, 18);
    check("fill_hwm", hwm, 18);
    check("fill_head", out_data, 1);

    n_pop = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && n_pop < 18; c++) begin
      pop = out_valid && out_ready;
      if (pop) check($sformatf("drain_data%0d", n_pop), out_data, n_pop + 1);
      step();
      if (pop) begin
        n_pop++;
        if (n_pop == 1) check("drain_in_ready_after_first_pop", in_ready, 1);
      end
    end
    check("drain_count", n_pop, 18);
    check("drain_usedw", usedw, 0);

    // Streaming: one push and one pop per cycle; three words in flight.
    pushed = 0; popped = 0; first_c = -1; last_c = -1; bad = 0;
    for (int c = 0; c < 300 && popped < 100; c++) begin
      in_valid = (pushed < 100); in_data = DW'(32'h1000 + pushed); out_ready = 1'b1;
      acc = in_valid && in_ready;
      pop = out_valid;
      if (pop) begin
        check($sformatf("stream_data%0d", popped), out_data, 32'h1000 + popped);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (pop && in_valid && usedw != 3) bad++;
      step();
      if (acc) pushed++;
      if (pop) popped++;
    end
    in_valid = 1'b0;
    check("stream_count", popped, 100);
    check("stream_no_bubble", last_c - first_c, 99);
    check("stream_usedw_steady", bad, 0);

    // Random back-pressure; pointers wrap about a dozen times.
    pushed = 0; popped = 0; bad = 0; hold_prev = 1'b0; prev_data = '0;
    for (int c = 0; c < 3000 && popped < 200; c++) begin
      if (!in_valid && pushed < 200 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = {4'(pushed), 32'($urandom), 32'($urandom)};
      end
      out_ready = 1'($urandom_range(0, 1));
      if (hold_prev && (!out_valid || out_data !== prev_data)) bad++;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (acc) sb.push_back(in_data);
      if (pop) begin
        if (sb.size() == 0) check("bp_underflow", 1, 0);
        else check($sformatf("bp_data%0d", popped), out_data, sb.pop_front());
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      step();
      if (acc) begin pushed++; in_valid = 1'b0; end
      if (pop) popped++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_count", popped, 200);
    check("bp_hold_stable", bad, 0);

    // Flush with 5 entries held and a read in flight.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h50 + i);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("preflush_usedw", usedw, 5);
    flush = 1'b1; in_valid = 1'b1; in_data = DW'(8'hEE); out_ready = 1'b1;
    step();
    check("flush_out_valid", out_valid, 0);
    check("flush_usedw", usedw, 0);
    check("flush_hwm", hwm, 0);
    check("flush_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("flush_stale_dropped", out_valid, 0);
    check("flush_usedw_after", usedw, 0);
    in_valid = 1'b1; in_data = DW'(8'h3C);
    step();
    in_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && !out_valid; c++) step();
    if (out_valid) found = 1;
    check("flush_3c_appears", found, 1);
    check("flush_3c_data", out_data, 8'h3C);
    check("flush_3c_usedw", usedw, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("flush_3c_popped", out_valid, 0);
    check("flush_3c_usedw_after", usedw, 0);

    // Asynchronous reset mid-stream, asserted between clock edges.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h60 + i);
      step();
    end
    in_valid = 1'b0;
    check("prerst_out_valid", out_valid, 1);
    check("prerst_usedw", usedw, 4);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_usedw", usedw, 0);
    check("arst_hwm", hwm, 0);
    check("arst_in_ready", in_ready, 0);
    step();
    #2 rst = 1'b0;
    #1;
    check("arst_release_in_ready", in_ready, 1);
    repeat (4) step();
    check("arst_no_residual", out_valid, 0);
    check("arst_usedw_idle", usedw, 0);
    in_valid = 1'b1; in_data = DW'(8'h77);
    step();
    in_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && !out_valid; c++) step();
    if (out_valid) found = 1;
    check("arst_resume_appears", found, 1);
    check("arst_resume_data", out_data, 8'h77);
    check("arst_resume_usedw", usedw, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
